// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device transmitter for a PS/2 port. Sends one byte to the keyboard
// with the usual framing: inhibit, request-to-send, start, 8 data bits LSB
// first, odd parity, stop, then the device ACK. The pins are open-drain. This
// block only pulls a line low through an output-enable and never drives one
// high.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high
//   cmd_data     byte to send
//   cmd_valid    send request; the byte is taken on cmd_valid & cmd_ready
//   cmd_ready    high only while idle
//   ps2_clk_in   raw PS2_CLK pin level (asynchronous)
//   ps2_dat_in   raw PS2_DAT pin level (asynchronous)
//   ps2_clk_oe   1 = pull PS2_CLK low, 0 = release
//   ps2_dat_oe   1 = pull PS2_DAT low, 0 = release
//   busy         high in every state except idle; the receive path masks on it
//   done         one-cycle pulse: byte sent and ACKed by the device
//   error        one-cycle pulse: timeout or missing ACK
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES       = 5000,
    parameter int unsigned START_TIMEOUT_CYCLES = 750000,
    parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000,
    parameter int unsigned IDLE_TIMEOUT_CYCLES  = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_INHIBIT    = 4'd1;
    localparam logic [3:0] S_RTS        = 4'd2;
    localparam logic [3:0] S_WAIT_START = 4'd3;
    localparam logic [3:0] S_SHIFT      = 4'd4;
    localparam logic [3:0] S_ACK        = 4'd5;
    localparam logic [3:0] S_WAIT_IDLE  = 4'd6;
    localparam logic [3:0] S_DONE       = 4'd7;
    localparam logic [3:0] S_ERR        = 4'd8;

    localparam logic [31:0] INH_LAST   = INHIBIT_CYCLES - 1;
    localparam logic [31:0] START_LAST = START_TIMEOUT_CYCLES - 1;
    localparam logic [31:0] XFER_LAST  = XFER_TIMEOUT_CYCLES - 1;
    localparam logic [31:0] IDLE_LAST  = IDLE_TIMEOUT_CYCLES - 1;

    logic [3:0]  state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic        parity_q, parity_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  nbit_q, nbit_d;
    logic        hi_q, hi_d;
    logic        clk_oe_q, clk_oe_d;
    logic        dat_oe_q, dat_oe_d;

    // Two-flop synchronizers. They reset to 1 because an idle bus floats high.
    logic [1:0]  clk_sync_q;
    logic [1:0]  dat_sync_q;
    logic        clk_prev_q;

    logic        clk_s;
    logic        dat_s;
    logic        fe;
    logic [3:0]  nbit_nx;

    assign clk_s   = clk_sync_q[1];
    assign dat_s   = dat_sync_q[1];
    assign fe      = clk_prev_q & ~clk_s;
    assign nbit_nx = nbit_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        parity_d = parity_q;
        cnt_d    = cnt_q;
        nbit_d   = nbit_q;
        hi_d     = hi_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;

        case (state_q)
            S_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                cnt_d    = '0;
                if (cmd_valid) begin
                    data_d   = cmd_data;
                    parity_d = ~^cmd_data;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = S_RTS;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            // The start bit (data low) is already on the line, so releasing
            // the clock here hands clocking over to the device.
            S_RTS: begin
                clk_oe_d = 1'b0;
                cnt_d    = '0;
                state_d  = S_WAIT_START;
            end

            // The first device edge presents data bit 0. The counter restarts
            // here and keeps running until the ACK is sampled.
            S_WAIT_START: begin
                if (fe) begin
                    dat_oe_d = ~data_q[0];
                    nbit_d   = 4'd1;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end else if (cnt_q == START_LAST) begin
                    dat_oe_d = 1'b0;
                    state_d  = S_ERR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_SHIFT: begin
                cnt_d = cnt_q + 32'd1;
                if (fe) begin
                    nbit_d = nbit_nx;
                    if (nbit_nx <= 4'd8) begin
                        dat_oe_d = ~data_q[nbit_q[2:0]];
                    end else if (nbit_nx == 4'd9) begin
                        dat_oe_d = ~parity_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = S_ACK;
                    end
                end else if (cnt_q == XFER_LAST) begin
                    dat_oe_d = 1'b0;
                    state_d  = S_ERR;
                end
            end

            S_ACK: begin
                cnt_d = cnt_q + 32'd1;
                if (fe) begin
                    if (!dat_s) begin
                        cnt_d   = '0;
                        hi_d    = 1'b0;
                        state_d = S_WAIT_IDLE;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (cnt_q == XFER_LAST) begin
                    state_d = S_ERR;
                end
            end

            // hi_q records that the previous cycle already saw both lines high.
            S_WAIT_IDLE: begin
                cnt_d = cnt_q + 32'd1;
                if (clk_s && dat_s && hi_q) begin
                    state_d = S_DONE;
                end else if (cnt_q == IDLE_LAST) begin
                    state_d = S_ERR;
                end else begin
                    hi_d = clk_s & dat_s;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_ERR: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end

            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            parity_q   <= 1'b0;
            cnt_q      <= '0;
            nbit_q     <= '0;
            hi_q       <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            cnt_q      <= cnt_d;
            nbit_q     <= nbit_d;
            hi_q       <= hi_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
            clk_prev_q <= clk_s;
        end
    end

    // The line enables come straight from flops, so an asynchronous reset
    // releases both pins at once.
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Bench for ps2_host_tx. A behavioural PS/2 device pulls the bus lines low and
// captures the frame it receives. A per-cycle monitor checks the handshake
// invariants and records pulses and accepted bytes. Scenario tasks compare the
// captured frames and the outcomes against a model that works from the byte.
module tb_ps2_host_tx;

    localparam int INH      = 200;
    localparam int START_TO = 1000;
    localparam int XFER_TO  = 2000;
    localparam int IDLE_TO  = 500;
    localparam int H        = 25;     // device half clock period in clk cycles
    localparam int LIMIT    = 20000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error;
    logic       ps2_clk_in, ps2_dat_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    // Open-drain bus: a line reads low if either side pulls it low.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES      (INH),
        .START_TIMEOUT_CYCLES(START_TO),
        .XFER_TIMEOUT_CYCLES (XFER_TO),
        .IDLE_TIMEOUT_CYCLES (IDLE_TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference frame as the device sees it on the wire:
    // {stop=1, odd parity, data[7:0], start=0}.
    function automatic logic [10:0] frame(input logic [7:0] b);
        int         ones;
        logic [7:0] t;
        logic       par;
        ones = 0;
        t    = b;
        for (int i = 0; i < 8; i++) begin
            if (t[0]) ones++;
            t = t >> 1;
        end
        par = ((ones % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Behavioural device. It answers a request-to-send (clock released, data
    // low), clocks 11 pulses, samples on each rising edge and optionally ACKs.
    bit         dev_enable = 1'b1;
    bit         dev_ack_en = 1'b1;
    bit         dev_busy   = 1'b0;
    int         dev_fe     = 0;
    logic [10:0] cap       = '0;

    initial begin : device
        forever begin
            @(negedge clk);
            if (dev_enable && !reset && ps2_clk_in && !ps2_dat_in) begin
                dev_busy = 1'b1;
                dev_fe   = 0;
                repeat (H) @(negedge clk);
                cap = {ps2_dat_in, cap[10:1]};
                for (int k = 1; k <= 11; k++) begin
                    dev_clk_low = 1'b1;
                    dev_fe      = k;
                    repeat (H) @(negedge clk);
                    dev_clk_low = 1'b0;
                    if (k <= 10) cap = {ps2_dat_in, cap[10:1]};
                    if (k == 10 && dev_ack_en) dev_dat_low = 1'b1;
                    if (k == 11) dev_dat_low = 1'b0;
                    repeat (H) @(negedge clk);
                end
                dev_busy = 1'b0;
            end
        end
    end

    // Per-cycle monitor, sampling on the falling clk edge.
    int         cyc = 0, done_cnt = 0, err_cnt = 0;
    int         clk_run = 0, last_inhibit = 0, rel_cyc = 0, err_cyc = 0, last_done_cyc = 0;
    logic       prev_clk_oe = 1'b0;
    logic [7:0] acc_q[$];
    int         acc_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            check("ready_is_not_busy", cmd_ready, !busy);
            check("done_error_exclusive", done & error, 0);
            if (ps2_clk_oe || ps2_dat_oe) check("oe_implies_busy", busy, 1);
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (error) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (ps2_clk_oe) begin
                clk_run++;
            end else if (prev_clk_oe) begin
                last_inhibit = clk_run;
                clk_run      = 0;
                rel_cyc      = cyc;
            end
            if (cmd_valid && cmd_ready) begin
                acc_q.push_back(cmd_data);
                acc_cyc.push_back(cyc);
            end
        end else begin
            clk_run = 0;
        end
        prev_clk_oe = ps2_clk_oe;
    end

    logic end_clk_oe, end_dat_oe;

    task automatic wait_ready();
        int t;
        t = 0;
        while (!cmd_ready && t < LIMIT) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= LIMIT) begin
            n_tests++; n_fail++;
            $display("FAIL wait_ready: cmd_ready stayed 0 for %0d cycles, expected 1", LIMIT);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        cmd_data  = b;
        cmd_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Result: 1 = done, 2 = error, 0 = neither within the bound.
    task automatic wait_end(output int res);
        res = 0;
        for (int t = 0; t < LIMIT && res == 0; t++) begin
            @(posedge clk); #1;
            if (done) res = 1;
            else if (error) res = 2;
        end
        end_clk_oe = ps2_clk_oe;
        end_dat_oe = ps2_dat_oe;
        if (res == 0) begin
            n_tests++; n_fail++;
            $display("FAIL wait_end: no done/error in %0d cycles, expected one", LIMIT);
        end
    endtask

    task automatic wait_dev_idle();
        int t;
        t = 0;
        while (dev_busy && t < LIMIT) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= LIMIT) begin
            n_tests++; n_fail++;
            $display("FAIL wait_dev_idle: device still busy after %0d cycles, expected idle", LIMIT);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // One complete transfer compared against the model.
    task automatic xfer(input logic [7:0] b, input bit ack);
        int d0, e0, res;
        d0 = done_cnt;
        e0 = err_cnt;
        dev_ack_en = ack;
        send(b);
        wait_end(res);
        check("outcome", res, ack ? 1 : 2);
        check("end_clk_oe", end_clk_oe, 0);
        if (!ack) check("err_dat_oe", end_dat_oe, 0);
        wait_dev_idle();
        check("frame", cap, frame(b));
        check("inhibit_len", last_inhibit, INH + 1);
        check("done_pulses", done_cnt - d0, ack ? 1 : 0);
        check("error_pulses", err_cnt - e0, ack ? 0 : 1);
        check("ready_after", cmd_ready, 1);
        check("lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);
    endtask

    initial begin : main
        int         res, d0, e0;
        logic [7:0] b;

        // Reset state, sampled while reset is still held.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_dat_oe", ps2_dat_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", cmd_ready, 1);

        // 0xED: wire bits 1,0,1,1,0,1,1,1, parity 1.
        xfer(8'hED, 1'b1);
        check("ed_byte", cap[8:1], 8'hED);
        check("ed_parity", cap[9], 1);
        check("ed_start", cap[0], 0);

        // 0xF4 has five ones, so parity 0.
        xfer(8'hF4, 1'b1);
        check("f4_byte", cap[8:1], 8'hF4);
        check("f4_parity", cap[9], 0);

        // Missing ACK.
        xfer(8'h3C, 1'b0);

        // Device never clocks: error exactly START_TO cycles after release.
        dev_enable = 1'b0;
        send(8'hA5);
        wait_end(res);
        check("start_to_outcome", res, 2);
        check("start_to_clk_oe", end_clk_oe, 0);
        check("start_to_dat_oe", end_dat_oe, 0);
        @(posedge clk); #1;
        check("start_to_delay", err_cyc - rel_cyc, START_TO);
        check("start_to_ready", cmd_ready, 1);
        dev_enable = 1'b1;

        // Reset after the 4th device falling edge of 0xFF.
        d0 = done_cnt;
        e0 = err_cnt;
        dev_ack_en = 1'b1;
        send(8'hFF);
        for (int t = 0; t < LIMIT && dev_fe < 4; t++) begin
            @(posedge clk); #1;
        end
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("async_rst_clk_oe", ps2_clk_oe, 0);
        check("async_rst_dat_oe", ps2_dat_oe, 0);
        check("async_rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_dev_idle();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_error", err_cnt - e0, 0);
        xfer(8'hFF, 1'b1);

        // cmd_valid held with 0x01 while 0xED is in flight.
        acc_q.delete();
        acc_cyc.delete();
        dev_ack_en = 1'b1;
        @(posedge clk); #1;
        cmd_data  = 8'hED;
        cmd_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        cmd_data = 8'h01;
        wait_end(res);
        check("hold_first_outcome", res, 1);
        check("hold_first_frame", cap, frame(8'hED));
        @(posedge clk); #1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("hold_accept_count", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            check("hold_accept0", acc_q[0], 8'hED);
            check("hold_accept1", acc_q[1], 8'h01);
            check("hold_accept1_cycle", acc_cyc[1] - last_done_cyc, 1);
        end
        wait_end(res);
        check("hold_second_outcome", res, 1);
        wait_dev_idle();
        check("hold_second_frame", cap, frame(8'h01));

        // Random bytes with a random ACK decision.
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            xfer(b, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
